// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: shared FSM state type and width helpers for the folded adder tree
package adder_tree_pkg;
    typedef enum logic [1:0] {LOAD, REDUCE, DONE} state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int sum_width(input int w, input int n);
        return w + clog2(n);
    endfunction
endpackage

// File: rtl/adder_tree_branch.sv
// adder_tree_branch: two-input unsigned adder whose output is one bit wider than its inputs
module adder_tree_branch #(
    parameter int ADDER_WIDTH = 20,
    parameter int EXTRA_BITS  = 0
) (
    input  logic [ADDER_WIDTH+EXTRA_BITS-1:0] i_a,
    input  logic [ADDER_WIDTH+EXTRA_BITS-1:0] i_b,
    output logic [ADDER_WIDTH+EXTRA_BITS:0]   o_sum
);
    assign o_sum = {1'b0, i_a} + {1'b0, i_b};
endmodule

// File: rtl/adder_tree_folded_seq.sv
// adder_tree_folded_seq: loads a batch of operands, then reduces it in place
// level by level through one shared adder and presents the total on valid/ready.
module adder_tree_folded_seq
    import adder_tree_pkg::*;
#(
    parameter int ADDER_WIDTH  = 20,
    parameter int NUM_OPERANDS = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [ADDER_WIDTH-1:0]                                in_data,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [sum_width(ADDER_WIDTH, NUM_OPERANDS)-1:0]       out_sum,
    output logic                                                  busy
);
    localparam int LOG2N = clog2(NUM_OPERANDS);
    localparam int SW    = sum_width(ADDER_WIDTH, NUM_OPERANDS);

    state_t           r_state, w_next;
    logic [LOG2N-1:0] r_cnt, r_p, r_level;
    logic [LOG2N-1:0] w_last_p, w_ia, w_ib;
    logic [SW-1:0]    r_buf [NUM_OPERANDS];
    logic [SW-1:0]    w_sum;
    logic             w_accept, w_last_beat, w_pair_end, w_last_level;

    assign w_accept     = (r_state == LOAD) && in_valid;
    assign w_last_beat  = r_cnt == LOG2N'(NUM_OPERANDS - 1);
    assign w_last_p     = LOG2N'((NUM_OPERANDS >> (r_level + 1)) - 1);
    assign w_last_level = r_level == LOG2N'(LOG2N - 1);
    assign w_pair_end   = (r_state == REDUCE) && (r_p == w_last_p);
    // Pair p reads entries 2p and 2p+1 and writes back to p, which is never above 2p.
    assign w_ia         = r_p << 1;
    assign w_ib         = w_ia | LOG2N'(1);

    adder_tree_branch #(
        .ADDER_WIDTH(ADDER_WIDTH),
        .EXTRA_BITS (LOG2N - 1)
    ) u_add (
        .i_a  (r_buf[w_ia][SW-2:0]),
        .i_b  (r_buf[w_ib][SW-2:0]),
        .o_sum(w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_next    = (w_accept && w_last_beat)               ? REDUCE :
                    (w_pair_end && w_last_level)            ? DONE   :
                    ((r_state == DONE) && out_ready)        ? LOAD   : r_state;
        in_ready  = r_state == LOAD;
        out_valid = r_state == DONE;
        busy      = r_state != LOAD;
        out_sum   = (r_state == DONE) ? r_buf[0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_p     <= '0;
            r_level <= '0;
            for (int i = 0; i < NUM_OPERANDS; i++) r_buf[i] <= '0;
        end else if (w_accept) begin
            r_buf[r_cnt] <= SW'(in_data);
            r_cnt        <= r_cnt + LOG2N'(1);
            r_p          <= '0;
            r_level      <= '0;
        end else if (r_state == REDUCE) begin
            r_buf[r_p] <= w_sum;
            r_p        <= w_pair_end ? '0 : r_p + LOG2N'(1);
            r_level    <= r_level + LOG2N'(w_pair_end);
        end else if ((r_state == DONE) && out_ready) begin
            r_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_adder_tree_folded_seq.sv
// tb_adder_tree_folded_seq: random and directed batches checked against a running-sum model
module tb_adder_tree_folded_seq;
    localparam int W  = 20;
    localparam int N  = 8;
    localparam int SW = 23;

    logic          clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic          in_ready, out_valid, busy;
    logic [W-1:0]  in_data = '0;
    logic [SW-1:0] out_sum;
    int            checks = 0, errors = 0;

    // Model: a batch is in flight from its Nth accepted beat until the output handshake;
    // the sum becomes visible N-1 cycles after that last beat.
    int     m_cyc = 0, m_n = 0, m_valid_edge = 0;
    longint m_acc = 0, m_sum = 0;
    logic   m_pending = 0;
    logic   m_ev;
    assign m_ev = m_pending && (m_cyc > m_valid_edge);

    always #5 clk = ~clk;

    adder_tree_folded_seq #(.ADDER_WIDTH(W), .NUM_OPERANDS(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .busy(busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n       <= 0;
            m_acc     <= 0;
            m_pending <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (in_valid && !m_pending) begin
                if (m_n == N - 1) begin
                    m_sum        <= m_acc + longint'(in_data);
                    m_pending    <= 1;
                    m_valid_edge <= m_cyc + N - 1;
                    m_n          <= 0;
                    m_acc        <= 0;
                end else begin
                    m_acc <= m_acc + longint'(in_data);
                    m_n   <= m_n + 1;
                end
            end else if (m_ev && out_ready) begin
                m_pending <= 0;
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, !m_pending);
        check("out_valid", out_valid, m_ev);
        check("busy", busy, m_pending);
        check("out_sum", out_sum, m_ev ? m_sum : 0);
    end

    task automatic send(input logic [W-1:0] v, input int gap, output int waits);
        in_valid = 1;
        in_data  = v;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid  = 0;
        in_data   = W'($urandom);
        out_ready = 1'($urandom);
        repeat (gap) begin
            @(posedge clk);
            #1;
            in_data = W'($urandom);
        end
    endtask

    task automatic send_batch(input logic [W-1:0] v[N], input int gap, output int first_waits);
        int w;
        first_waits = 0;
        for (int i = 0; i < N; i++) begin
            send(v[i], (i == N - 1) ? 0 : (gap < 0 ? int'($urandom_range(0, 3)) : gap), w);
            if (i == 0) first_waits = w;
        end
        out_ready = 0;
    endtask

    task automatic wait_out(input string tag, input int hold, input longint exp);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        check({tag, "_latency"}, lat - 1, N - 1);
        repeat (hold) begin
            check({tag, "_hold_sum"}, out_sum, exp);
            check({tag, "_hold_in_ready"}, in_ready, 0);
            @(negedge clk);
        end
        check({tag, "_sum"}, out_sum, exp);
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        check({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] v[N];
        longint       s;
        int           fw;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_sum", out_sum, 0);
        @(posedge clk);
        #1 rst_n = 1;

        for (int i = 0; i < N; i++) v[i] = W'(i + 1);
        send_batch(v, 0, fw);
        wait_out("seq", 0, 36);

        for (int i = 0; i < N; i++) v[i] = 20'hFFFFF;
        send_batch(v, 0, fw);
        wait_out("max", 0, 64'h7FFFF8);

        for (int i = 0; i < N; i++) v[i] = W'(i + 1);
        send_batch(v, 1, fw);
        wait_out("gap", 0, 36);

        send_batch(v, 0, fw);
        wait_out("stall", 5, 36);

        send_batch(v, 0, fw);
        repeat (5) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_sum", out_sum, 0);
        @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < N; i++) v[i] = W'(10 * (i + 1));
        send_batch(v, 0, fw);
        wait_out("after_rst", 0, 360);

        for (int i = 0; i < N; i++) v[i] = W'(i + 1);
        send_batch(v, 0, fw);
        wait_out("b2b_first", 0, 36);
        for (int i = 0; i < N; i++) v[i] = W'(1);
        send_batch(v, 0, fw);
        check("b2b_first_beat_waits", fw, 0);
        wait_out("b2b_second", 0, 8);

        for (int b = 0; b < 20; b++) begin
            s = 0;
            for (int i = 0; i < N; i++) begin
                v[i] = W'($urandom);
                s += longint'(v[i]);
            end
            send_batch(v, -1, fw);
            wait_out("rand", int'($urandom_range(0, 3)), s);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
